// File: rtl/deser_pkg.sv
// Shared types and framing constants for the serial deserializer.
// Both the top module and the output buffer import this package.
package deser_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } deser_state_t;

    localparam logic START_BIT = 1'b0;
    localparam logic STOP_BIT  = 1'b1;

endpackage

// File: rtl/deser_out_buffer.sv
// One-entry valid/ready holding register for assembled words.
// A commit into a full, unconsumed buffer is dropped and flagged.
module deser_out_buffer
    import deser_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             i_commit,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_ready,
    output logic [WIDTH-1:0] o_data,
    output logic             o_valid,
    output logic             o_overrun
);

    logic [WIDTH-1:0] r_data;
    logic             r_valid;
    logic             r_overrun;
    logic             w_free;

    // Slot is free when empty or being drained this very cycle.
    assign w_free = !r_valid || i_ready;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_data    <= '0;
            r_valid   <= 1'b0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= 1'b0;
            if (i_commit) begin
                if (w_free) begin
                    r_data  <= i_data;
                    r_valid <= 1'b1;
                end else begin
                    r_overrun <= 1'b1;
                end
            end else if (r_valid && i_ready) begin
                r_valid <= 1'b0;
            end
        end
    end

    assign o_data    = r_data;
    assign o_valid   = r_valid;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/serial_deserializer.sv
// Framed serial-to-parallel receiver: start 0, WIDTH data bits LSB first, stop 1.
// Define DESERIALIZER_PARITY_EN to add an even-parity bit before the stop bit.
module serial_deserializer
    import deser_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    input  logic             din_valid,
    output logic [WIDTH-1:0] out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             frame_err,
    output logic             overrun,
    output logic             parity_err
);

    deser_state_t     r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [WIDTH-1:0] r_shift;
    logic             r_frame_err;
    logic             w_last;
    logic             w_stop_ok;
    logic             w_par_bad;
    logic             w_commit;

`ifdef DESERIALIZER_PARITY_EN
    logic             r_par;
    logic             r_parity_err;
    assign w_par_bad  = ^{r_shift, r_par};
    assign parity_err = r_parity_err;
`else
    assign w_par_bad  = 1'b0;
    assign parity_err = 1'b0;
`endif

    assign w_last    = (r_cnt == CNT_W'(WIDTH - 1));
    assign w_stop_ok = din_valid && (r_state == STOP) && (din == STOP_BIT);
    assign w_commit  = w_stop_ok && !w_par_bad;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_shift     <= '0;
            r_frame_err <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
            r_par        <= 1'b0;
            r_parity_err <= 1'b0;
`endif
        end else begin
            r_frame_err <= 1'b0;
`ifdef DESERIALIZER_PARITY_EN
            r_parity_err <= 1'b0;
`endif
            if (din_valid) begin
                unique case (r_state)
                    IDLE: begin
                        if (din == START_BIT) begin
                            r_state <= DATA;
                            r_cnt   <= '0;
                        end
                    end
                    DATA: begin
                        r_shift[r_cnt] <= din;
                        r_cnt          <= r_cnt + 1'b1;
                        if (w_last) begin
`ifdef DESERIALIZER_PARITY_EN
                            r_state <= PARITY;
`else
                            r_state <= STOP;
`endif
                        end
                    end
                    PARITY: begin
`ifdef DESERIALIZER_PARITY_EN
                        r_par <= din;
`endif
                        r_state <= STOP;
                    end
                    STOP: begin
                        // A bad stop bit masks any parity error.
                        r_frame_err <= (din != STOP_BIT);
`ifdef DESERIALIZER_PARITY_EN
                        r_parity_err <= (din == STOP_BIT) && w_par_bad;
`endif
                        r_state <= IDLE;
                    end
                    default: r_state <= IDLE;
                endcase
            end
        end
    end

    assign frame_err = r_frame_err;

    deser_out_buffer #(
        .WIDTH (WIDTH)
    ) u_buf (
        .clk       (clk),
        .reset     (reset),
        .i_commit  (w_commit),
        .i_data    (r_shift),
        .i_ready   (out_ready),
        .o_data    (out_data),
        .o_valid   (out_valid),
        .o_overrun (overrun)
    );

endmodule

// File: tb/tb_serial_deserializer.sv
// Directed bench for serial_deserializer: vector table plus corner sequences.
// Define DESERIALIZER_PARITY_EN here as for the RTL to exercise parity.
module tb_serial_deserializer;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       din = 1'b1;
    logic       din_valid = 1'b0;
    logic       out_ready = 1'b1;
    logic [7:0] out_data;
    logic       out_valid;
    logic       frame_err;
    logic       overrun;
    logic       parity_err;

    int n_chk = 0;
    int n_fail = 0;

    int         n_words = 0;
    int         n_ferr = 0;
    int         n_perr = 0;
    int         n_ovr = 0;
    logic [7:0] last_word = 8'h00;

    serial_deserializer #(.WIDTH(8)) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .din_valid  (din_valid),
        .out_data   (out_data),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .frame_err  (frame_err),
        .overrun    (overrun),
        .parity_err (parity_err)
    );

    always #5 clk = ~clk;

    // Event monitor: samples the values that were stable through the last cycle.
    always @(posedge clk) begin
        if (reset) begin
            if (out_valid && out_ready) begin
                n_words   <= n_words + 1;
                last_word <= out_data;
            end
            if (frame_err)  n_ferr <= n_ferr + 1;
            if (parity_err) n_perr <= n_perr + 1;
            if (overrun)    n_ovr  <= n_ovr + 1;
        end
    end

    typedef struct {
        int         idle1;
        logic [7:0] data;
        logic       pflip;
        logic       stopb;
        int         gap;
        int         exp_words;
        logic [7:0] exp_word;
        int         exp_ferr;
        int         exp_perr;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            din       = 1'b1;
            din_valid = 1'b0;
        end
    endtask

    task automatic strobe(input logic b);
        @(negedge clk);
        din       = b;
        din_valid = 1'b1;
    endtask

    // Returns with the stop bit still strobed in the current cycle.
    task automatic send_frame(input logic [7:0] d, input logic pf,
                              input logic sb, input int gap);
        logic fb[$];
        fb.push_back(1'b0);
        for (int i = 0; i < 8; i++) fb.push_back(d[i]);
`ifdef DESERIALIZER_PARITY_EN
        fb.push_back((^d) ^ pf);
`endif
        fb.push_back(sb);
        foreach (fb[i]) begin
            strobe(fb[i]);
            if (i != fb.size() - 1) begin
                repeat (gap) begin
                    @(negedge clk);
                    din_valid = 1'b0;
                    din       = 1'b0;
                end
            end
        end
    endtask

    vec_t tbl[$];
    int   wb, fb0, pb, ob;

    initial begin
        tbl.push_back('{0, 8'hA5, 1'b0, 1'b1, 0, 1, 8'hA5, 0, 0});
        tbl.push_back('{5, 8'h3C, 1'b0, 1'b1, 2, 1, 8'h3C, 0, 0});
        tbl.push_back('{0, 8'hFF, 1'b0, 1'b0, 0, 0, 8'h00, 1, 0});
        tbl.push_back('{0, 8'h01, 1'b0, 1'b1, 0, 1, 8'h01, 0, 0});
        tbl.push_back('{2, 8'h5A, 1'b0, 1'b1, 1, 1, 8'h5A, 0, 0});
`ifdef DESERIALIZER_PARITY_EN
        tbl.push_back('{0, 8'hA5, 1'b1, 1'b1, 0, 0, 8'h00, 0, 1});
        tbl.push_back('{0, 8'hA5, 1'b0, 1'b1, 0, 1, 8'hA5, 0, 0});
        tbl.push_back('{0, 8'h33, 1'b1, 1'b0, 0, 0, 8'h00, 1, 0});
`endif

        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data", 32'(out_data), 32'd0);
        chk("rst_ferr", 32'(frame_err), 32'd0);
        chk("rst_ovr", 32'(overrun), 32'd0);
        chk("rst_perr", 32'(parity_err), 32'd0);
        reset = 1'b1;
        idle(2);

        // Nominal frame: visible exactly one cycle after the stop strobe.
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        idle(1);
        chk("nom_valid", 32'(out_valid), 32'd1);
        chk("nom_data", 32'(out_data), 32'hA5);
        chk("nom_ferr", 32'(frame_err), 32'd0);
        idle(1);
        chk("nom_drop", 32'(out_valid), 32'd0);
        idle(2);

        foreach (tbl[k]) begin
            wb  = n_words;
            fb0 = n_ferr;
            pb  = n_perr;
            ob  = n_ovr;
            repeat (tbl[k].idle1) strobe(1'b1);
            send_frame(tbl[k].data, tbl[k].pflip, tbl[k].stopb, tbl[k].gap);
            idle(3);
            chk($sformatf("v%0d_words", k), 32'(n_words - wb),
                32'(tbl[k].exp_words));
            if (tbl[k].exp_words > 0)
                chk($sformatf("v%0d_word", k), 32'(last_word),
                    32'(tbl[k].exp_word));
            chk($sformatf("v%0d_ferr", k), 32'(n_ferr - fb0),
                32'(tbl[k].exp_ferr));
            chk($sformatf("v%0d_perr", k), 32'(n_perr - pb),
                32'(tbl[k].exp_perr));
            chk($sformatf("v%0d_ovr", k), 32'(n_ovr - ob), 32'd0);
        end

        // Backpressure: second word dropped with a single overrun pulse.
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 0);
        idle(2);
        chk("bp_valid", 32'(out_valid), 32'd1);
        ob = n_ovr;
        send_frame(8'h22, 1'b0, 1'b1, 0);
        idle(1);
        chk("bp_ovr_pulse", 32'(overrun), 32'd1);
        chk("bp_hold", 32'(out_data), 32'h11);
        idle(1);
        chk("bp_ovr_end", 32'(overrun), 32'd0);
        chk("bp_ovr_cnt", 32'(n_ovr - ob), 32'd1);
        wb = n_words;
        out_ready = 1'b1;
        idle(1);
        chk("bp_drain", 32'(out_valid), 32'd0);
        chk("bp_words", 32'(n_words - wb), 32'd1);
        chk("bp_word", 32'(last_word), 32'h11);
        idle(2);

        // Consume and commit in the same cycle.
        out_ready = 1'b0;
        send_frame(8'h11, 1'b0, 1'b1, 0);
        idle(2);
        wb = n_words;
        ob = n_ovr;
        send_frame(8'h22, 1'b0, 1'b1, 0);
        out_ready = 1'b1;
        idle(1);
        chk("sim_valid", 32'(out_valid), 32'd1);
        chk("sim_data", 32'(out_data), 32'h22);
        chk("sim_ovr", 32'(overrun), 32'd0);
        idle(1);
        chk("sim_drop", 32'(out_valid), 32'd0);
        chk("sim_words", 32'(n_words - wb), 32'd2);
        chk("sim_word", 32'(last_word), 32'h22);
        chk("sim_ovr_cnt", 32'(n_ovr - ob), 32'd0);
        idle(2);

        // Reset mid-frame clears the buffer and aborts the frame silently.
        out_ready = 1'b0;
        send_frame(8'h77, 1'b0, 1'b1, 0);
        idle(2);
        chk("mr_pre_valid", 32'(out_valid), 32'd1);
        strobe(1'b0);
        strobe(1'b1);
        strobe(1'b1);
        strobe(1'b0);
        strobe(1'b1);
        @(negedge clk);
        din_valid = 1'b0;
        reset     = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        chk("mr_valid", 32'(out_valid), 32'd0);
        chk("mr_data", 32'(out_data), 32'd0);
        chk("mr_ferr", 32'(frame_err), 32'd0);
        chk("mr_ovr", 32'(overrun), 32'd0);
        chk("mr_perr", 32'(parity_err), 32'd0);
        out_ready = 1'b1;
        wb  = n_words;
        fb0 = n_ferr;
        send_frame(8'h5A, 1'b0, 1'b1, 0);
        idle(3);
        chk("mr_words", 32'(n_words - wb), 32'd1);
        chk("mr_word", 32'(last_word), 32'h5A);
        chk("mr_ferr_cnt", 32'(n_ferr - fb0), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
